// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock through a single
// full-subtractor cell. The borrow ripples LSB->MSB through a register.
// Operands are latched on an accepted start; done pulses for one cycle once
// d/bout/borrows are final, and they hold until the next accepted start.
module serial_ripple_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic [WIDTH-1:0] borrows
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH-1:0] brw_q, brw_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             last_bit;
  logic [IW-1:0]    idx;
  logic             ai, bi, di, nb;

  // start is honoured only between operations
  assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign idx      = cnt_q[IW-1:0];

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: DONE lasts one cycle, or relaunches on start
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Full-subtractor cell on the current bit plus datapath next-state
  always_comb begin
    ai     = a_q[idx];
    bi     = b_q[idx];
    di     = ai ^ bi ^ br_q;
    nb     = (~ai & bi) | (~(ai ^ bi) & br_q);

    a_d    = a_q;
    b_d    = b_q;
    diff_d = diff_q;
    brw_d  = brw_q;
    br_d   = br_q;
    bout_d = bout_q;
    cnt_d  = cnt_q;

    if (accept) begin
      a_d    = a;
      b_d    = b;
      br_d   = bin;
      cnt_d  = '0;
      diff_d = '0;
      brw_d  = '0;
      bout_d = 1'b0;
    end else if (state_q == S_RUN) begin
      diff_d[idx] = di;
      brw_d[idx]  = nb;
      br_d        = nb;
      cnt_d       = cnt_q + CW'(1);
      if (last_bit) bout_d = nb;
    end
  end

  // Datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      brw_q  <= '0;
      br_q   <= 1'b0;
      bout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      diff_q <= diff_d;
      brw_q  <= brw_d;
      br_q   <= br_d;
      bout_q <= bout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign d       = diff_q;
  assign borrows = brw_q;
  assign bout    = bout_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed and exhaustive checks for the 4-bit serial ripple subtractor.
module tb_serial_ripple_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout;
  logic [W-1:0] d, borrows;

  int unsigned  errors = 0;
  int unsigned  checks = 0;

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .d       (d),
    .bout    (bout),
    .borrows (borrows)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-bit borrow chain: borrow out of bit i iff low (i+1) bits of a < those of b plus bin
  function automatic logic [W-1:0] model_brw(input int av, input int bv, input int bi);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      int m;
      m = 1 << (i + 1);
      r[i] = ((av % m) < ((bv % m) + bi));
    end
    return r;
  endfunction

  // One isolated operation with hand-computed expectations
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bi, input logic [W-1:0] ed, input logic eb,
                        input logic [W-1:0] ebrw);
    a = av; b = bv; bin = bi; start = 1'b1;
    step();
    start = 1'b0;
    a = ~av; b = ~bv; bin = ~bi;  // latched operands must not follow the inputs
    for (int k = 0; k < W; k++) begin
      check({tag, "_busy"}, {30'd0, busy, done}, 32'b10);
      if (k < W - 1) step();
    end
    step();
    check({tag, "_done"}, {30'd0, busy, done}, 32'b01);
    check({tag, "_d"}, 32'(d), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
    check({tag, "_brw"}, 32'(borrows), 32'(ebrw));
    step();
    check({tag, "_idle"}, {30'd0, busy, done}, 32'b00);
    check({tag, "_hold"}, {27'd0, bout, d}, {27'd0, eb, ed});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    step();
    step();
    check("rst_state", {20'd0, busy, done, bout, d, borrows}, 32'd0);
    rst = 1'b0;
    step();
    check("idle", {30'd0, busy, done}, 32'b00);

    // 9-3: borrow generated at bit1, propagated at bit2, absorbed at bit3
    run_op("s9m3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 4'b0110);
    run_op("s3m9", 4'd3, 4'd9, 1'b0, 4'b1010, 1'b1, 4'b1000);
    run_op("s0m0b", 4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 4'b1111);
    run_op("s15m15b", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 4'b1111);
    run_op("s8m1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 4'b0111);
    run_op("s15m0", 4'd15, 4'd0, 1'b0, 4'd15, 1'b0, 4'b0000);

    // start held through RUN with new operands: ignored, then relaunch from DONE
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    step();
    a = 4'd1; b = 4'd1;
    for (int k = 0; k < W; k++) begin
      check("hold_busy1", {30'd0, busy, done}, 32'b10);
      if (k < W - 1) step();
    end
    step();
    check("hold_done1", {30'd0, busy, done}, 32'b01);
    check("hold_res1", {23'd0, bout, d, borrows}, {23'd0, 1'b0, 4'd6, 4'b0110});
    step();
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      check("hold_busy2", {30'd0, busy, done}, 32'b10);
      if (k < W - 1) step();
    end
    step();
    check("hold_done2", {30'd0, busy, done}, 32'b01);
    check("hold_res2", {23'd0, bout, d, borrows}, 32'd0);
    step();

    // reset during second RUN cycle abandons the operation
    a = 4'd0; b = 4'd0; bin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("mid_busy", {30'd0, busy, done}, 32'b10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst", {20'd0, busy, done, bout, d, borrows}, 32'd0);
    for (int k = 0; k < W + 2; k++) begin
      step();
      check("mid_nodone", {30'd0, busy, done}, 32'b00);
    end

    // exhaustive back-to-back: start held high, one result every W+1 cycles
    a = '0; b = '0; bin = 1'b0; start = 1'b1;
    for (int n = 0; n < 512; n++) begin
      int av, bv, bi, diff;
      av = n[7:4]; bv = n[3:0]; bi = n[8];
      step();
      for (int k = 0; k < W; k++) begin
        check("ex_busy", {30'd0, busy, done}, 32'b10);
        if (k < W - 1) step();
      end
      step();
      diff = (av - bv - bi) & 31;
      check("ex_done", {30'd0, busy, done}, 32'b01);
      check("ex_diff", {27'd0, bout, d}, 32'(diff));
      check("ex_brw", 32'(borrows), 32'(model_brw(av, bv, bi)));
      if (n < 511) begin
        a = W'((n + 1) >> 4); b = W'(n + 1); bin = (((n + 1) >> 8) & 1) != 0;
      end else begin
        start = 1'b0;
      end
    end
    step();
    check("ex_end", {30'd0, busy, done}, 32'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
